// File: rtl/video_pkg.sv
// Shared video-path definitions: FVH flag bit positions, default geometry, locator FSM states.
package video_pkg;

  localparam int F_BIT = 2;
  localparam int V_BIT = 1;
  localparam int H_BIT = 0;

  localparam int DEF_X_W = 10;
  localparam int DEF_Y_W = 9;

  typedef enum logic [2:0] {
    SYNC,
    BLANK_V,
    WAIT_LINE,
    LINE,
    EMIT
  } lll_state_t;

endpackage

// File: rtl/laser_line_locator_if.sv
// Thresholded pixel stream in, per-row stripe report out; master drives pixels, slave is the locator.
interface laser_line_locator_if #(
  parameter int X_W = video_pkg::DEF_X_W,
  parameter int Y_W = video_pkg::DEF_Y_W
);

  logic [7:0]     din;
  logic [2:0]     fvh_in;
  logic           dv_in;
  logic           row_valid;
  logic [Y_W-1:0] row_idx;
  logic [X_W-1:0] centre;
  logic [X_W-1:0] run_len;
  logic           found;
  logic           field_out;
  logic           frame_done;

  modport master (
    output din, fvh_in, dv_in,
    input  row_valid, row_idx, centre, run_len, found, field_out, frame_done
  );

  modport slave (
    input  din, fvh_in, dv_in,
    output row_valid, row_idx, centre, run_len, found, field_out, frame_done
  );

endinterface

// File: rtl/laser_line_locator_run_tracker.sv
// Tracks the current white run and the best (longest, leftmost) run of a line.
// best_* outputs already fold in a run still open at line_end; state clears on line_end.
module run_tracker
  import video_pkg::*;
#(
  parameter int X_W     = DEF_X_W,
  parameter int MIN_RUN = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pixel,
  input  logic           active,
  input  logic           line_end,
  input  logic [X_W-1:0] col,
  output logic [X_W-1:0] best_start,
  output logic [X_W-1:0] best_len,
  output logic           found
);

  localparam logic [X_W-1:0] MIN_L = X_W'(MIN_RUN);

  logic           open_run;
  logic           cur_wins;
  logic [X_W-1:0] cur_start, cur_len;
  logic [X_W-1:0] best_start_q, best_len_q;

  // Strictly greater keeps the leftmost of equal-length runs.
  assign cur_wins   = open_run && (cur_len >= MIN_L) && (cur_len > best_len_q);
  assign best_start = cur_wins ? cur_start : best_start_q;
  assign best_len   = cur_wins ? cur_len   : best_len_q;
  assign found      = (best_len >= MIN_L);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_run     <= 1'b0;
      cur_start    <= '0;
      cur_len      <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else if (line_end) begin
      open_run     <= 1'b0;
      cur_start    <= '0;
      cur_len      <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else if (active) begin
      if (pixel) begin
        if (open_run) begin
          if (cur_len != '1) cur_len <= cur_len + X_W'(1);
        end else begin
          open_run  <= 1'b1;
          cur_start <= col;
          cur_len   <= X_W'(1);
        end
      end else begin
        if (cur_wins) begin
          best_start_q <= cur_start;
          best_len_q   <= cur_len;
        end
        open_run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/laser_line_locator.sv
// Per active line, reports centre/width/row of the longest white run (laser stripe).
// Result registered on the line-end sample edge; no backpressure, dv_in=0 simply stalls.
module laser_line_locator
  import video_pkg::*;
#(
  parameter int X_W     = DEF_X_W,
  parameter int Y_W     = DEF_Y_W,
  parameter int MIN_RUN = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  laser_line_locator_if.slave bus
);

  lll_state_t     state, state_nxt;
  logic           qual, active_px, trk_active, line_end, fd_set;
  logic           exit_v, field_lat, trk_found;
  logic [X_W-1:0] x, col, best_start, best_len;
  logic [Y_W-1:0] row_cnt;
  logic [X_W:0]   ctr_sum;
  logic           unused_din;

  // Only the MSB carries information after thresholding.
  assign unused_din = ^bus.din[6:0];

  assign qual       = bus.dv_in;
  assign active_px  = qual && (bus.fvh_in[V_BIT:H_BIT] == 2'b00);
  assign trk_active = active_px && ((state == WAIT_LINE) || (state == LINE));
  assign line_end   = (state == LINE) && qual && (bus.fvh_in[V_BIT] || bus.fvh_in[H_BIT]);
  assign col        = (state == LINE) ? x : '0;
  assign ctr_sum    = {1'b0, best_start} + {1'b0, best_start} + {1'b0, best_len} - (X_W+1)'(1);

  run_tracker #(.X_W(X_W), .MIN_RUN(MIN_RUN)) u_run_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .pixel      (bus.din[7]),
    .active     (trk_active),
    .line_end   (line_end),
    .col        (col),
    .best_start (best_start),
    .best_len   (best_len),
    .found      (trk_found)
  );

  always_comb begin
    state_nxt = state;
    fd_set    = 1'b0;
    unique case (state)
      SYNC:      if (qual && bus.fvh_in[V_BIT]) state_nxt = BLANK_V;
      BLANK_V:   if (qual && !bus.fvh_in[V_BIT]) state_nxt = WAIT_LINE;
      WAIT_LINE: begin
        if (qual && bus.fvh_in[V_BIT]) begin
          state_nxt = BLANK_V;
          fd_set    = (row_cnt != '0);
        end else if (active_px) begin
          state_nxt = LINE;
        end
      end
      LINE:      if (line_end) state_nxt = EMIT;
      EMIT: begin
        state_nxt = exit_v ? BLANK_V : WAIT_LINE;
        fd_set    = exit_v;
      end
      default:   state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= SYNC;
      x              <= '0;
      row_cnt        <= '0;
      field_lat      <= 1'b0;
      exit_v         <= 1'b0;
      bus.row_valid  <= 1'b0;
      bus.row_idx    <= '0;
      bus.centre     <= '0;
      bus.run_len    <= '0;
      bus.found      <= 1'b0;
      bus.field_out  <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      state          <= state_nxt;
      bus.row_valid  <= line_end;
      bus.frame_done <= fd_set;

      if ((state == BLANK_V) && (state_nxt == WAIT_LINE)) row_cnt <= '0;
      else if ((state == EMIT) && (row_cnt != '1))        row_cnt <= row_cnt + Y_W'(1);

      // The first active pixel is column 0, so the counter leaves WAIT_LINE at 1.
      if ((state == WAIT_LINE) && active_px) begin
        x         <= X_W'(1);
        field_lat <= bus.fvh_in[F_BIT];
      end else if ((state == LINE) && active_px && (x != '1)) begin
        x <= x + X_W'(1);
      end

      if (line_end) begin
        exit_v        <= bus.fvh_in[V_BIT];
        bus.row_idx   <= row_cnt;
        bus.field_out <= field_lat;
        bus.found     <= trk_found;
        bus.centre    <= trk_found ? ctr_sum[X_W:1] : '0;
        bus.run_len   <= trk_found ? best_len : '0;
      end
    end
  end

endmodule

// File: tb/tb_laser_line_locator.sv
// Directed + randomized line sequences checked against a run-length model of each line.
module tb_laser_line_locator;

  localparam int XW   = 10;
  localparam int YW   = 9;
  localparam int MINR = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  laser_line_locator_if #(.X_W(XW), .Y_W(YW)) bus ();

  laser_line_locator #(.X_W(XW), .Y_W(YW), .MIN_RUN(MINR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int rv_cnt = 0;
  int fd_cnt = 0;
  int stall_pct = 0;
  bit px [0:1023];

  always @(negedge clk) begin
    if (bus.row_valid === 1'b1)  rv_cnt++;
    if (bus.frame_done === 1'b1) fd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic dv, input logic [2:0] fvh, input logic [7:0] d);
    bus.dv_in  = dv;
    bus.fvh_in = fvh;
    bus.din    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic blank_v(input bit f, input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, {f, 1'b1, k[0]}, 8'h00);
  endtask

  task automatic clear_px();
    for (int i = 0; i < 1024; i++) px[i] = 1'b0;
  endtask

  task automatic set_run(input int a, input int b);
    for (int i = a; i <= b; i++) px[i] = 1'b1;
  endtask

  task automatic rand_line(input int w);
    int pos;
    int len;
    bit c;
    clear_px();
    pos = 0;
    while (pos < w) begin
      len = $urandom_range(9, 1);
      c   = 1'($urandom_range(1, 0));
      for (int j = 0; j < len && pos < w; j++) begin
        px[pos] = c;
        pos++;
      end
    end
  endtask

  // Longest run of at least MINR whites; first one found wins among equals.
  task automatic model(input int w, output int e_found, output int e_ctr, output int e_len);
    int bs, bl, st, len;
    bs = 0; bl = 0; st = 0; len = 0;
    for (int i = 0; i <= w; i++) begin
      if (i < w && px[i]) begin
        if (len == 0) st = i;
        len++;
      end else begin
        if (len >= MINR && len > bl) begin
          bl = len;
          bs = st;
        end
        len = 0;
      end
    end
    e_found = (bl > 0) ? 1 : 0;
    e_len   = bl;
    e_ctr   = (bl > 0) ? (2 * bs + bl - 1) / 2 : 0;
  endtask

  task automatic send_line(input int w, input bit f, input bit endv, input int stall_col,
                           input int stall_n, input int abort_col, input bit expect_rep,
                           input int exp_row);
    int ef, ec, el;
    for (int k = 0; k < 4; k++) cyc(1'b1, {f, 2'b01}, 8'h00);
    for (int i = 0; i < w; i++) begin
      if (i == abort_col) begin
        rst_n = 1'b0;
        #1;
        chk("rst_row_valid",  32'(bus.row_valid), 0);
        chk("rst_found",      32'(bus.found), 0);
        chk("rst_centre",     32'(bus.centre), 0);
        chk("rst_run_len",    32'(bus.run_len), 0);
        chk("rst_row_idx",    32'(bus.row_idx), 0);
        chk("rst_frame_done", 32'(bus.frame_done), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      if (i == stall_col)
        for (int k = 0; k < stall_n; k++) cyc(1'b0, 3'($urandom), 8'($urandom));
      if ($urandom_range(99, 0) < stall_pct) cyc(1'b0, 3'($urandom), 8'($urandom));
      cyc(1'b1, {f, 2'b00}, px[i] ? 8'hFF : 8'h00);
    end
    cyc(1'b1, {f, endv, 1'b1}, 8'h00);
    if (expect_rep) begin
      model(w, ef, ec, el);
      chk("row_valid",  32'(bus.row_valid), 1);
      chk("found",      32'(bus.found), 32'(ef));
      chk("centre",     32'(bus.centre), 32'(ec));
      chk("run_len",    32'(bus.run_len), 32'(el));
      chk("row_idx",    32'(bus.row_idx), 32'(exp_row));
      chk("field_out",  32'(bus.field_out), 32'(f));
    end
    cyc(1'b1, {f, endv, 1'b1}, 8'h00);
    if (expect_rep) chk("row_valid_one_cycle", 32'(bus.row_valid), 0);
  endtask

  initial begin
    int fd0, rv0, nl, w;
    bus.dv_in  = 1'b0;
    bus.fvh_in = 3'b000;
    bus.din    = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_row_valid",  32'(bus.row_valid), 0);
    chk("reset_found",      32'(bus.found), 0);
    chk("reset_centre",     32'(bus.centre), 0);
    chk("reset_run_len",    32'(bus.run_len), 0);
    chk("reset_row_idx",    32'(bus.row_idx), 0);
    chk("reset_field_out",  32'(bus.field_out), 0);
    chk("reset_frame_done", 32'(bus.frame_done), 0);
    rst_n = 1'b1;

    // Lines before any vertical blank must stay silent.
    clear_px(); set_run(10, 20);
    send_line(64, 1'b0, 1'b0, -1, 0, -1, 1'b0, 0);
    send_line(64, 1'b0, 1'b1, -1, 0, -1, 1'b0, 0);
    blank_v(1'b0, 6);
    chk("sync_no_rows", 32'(rv_cnt), 0);
    chk("sync_no_frame_done", 32'(fd_cnt), 0);

    // Directed field 0.
    fd0 = fd_cnt;
    clear_px(); set_run(300, 309);
    send_line(640, 1'b0, 1'b0, -1, 0, -1, 1'b1, 0);
    clear_px(); set_run(100, 101); set_run(400, 404);
    send_line(640, 1'b0, 1'b0, -1, 0, -1, 1'b1, 1);
    clear_px(); set_run(100, 101);
    send_line(640, 1'b0, 1'b0, -1, 0, -1, 1'b1, 2);
    clear_px(); set_run(50, 55); set_run(200, 205);
    send_line(640, 1'b0, 1'b0, -1, 0, -1, 1'b1, 3);
    clear_px(); set_run(636, 639);
    send_line(640, 1'b0, 1'b0, -1, 0, -1, 1'b1, 4);
    clear_px(); set_run(300, 309);
    send_line(640, 1'b0, 1'b0, 305, 7, -1, 1'b1, 5);
    clear_px(); set_run(0, 2);
    send_line(640, 1'b0, 1'b1, -1, 0, -1, 1'b1, 6);
    blank_v(1'b1, 5);
    chk("field0_frame_done", 32'(fd_cnt), 32'(fd0 + 1));

    // Randomized fields with random stalls; field bit alternates.
    stall_pct = 20;
    for (int fld = 0; fld < 4; fld++) begin
      fd0 = fd_cnt;
      nl  = (fld == 0) ? 3 : int'($urandom_range(6, 2));
      for (int r = 0; r < nl; r++) begin
        w = $urandom_range(256, 32);
        rand_line(w);
        send_line(w, fld[0] ^ 1'b1, (r == nl - 1), -1, 0, -1, 1'b1, r);
      end
      blank_v(fld[0], 4);
      chk("rand_frame_done", 32'(fd_cnt), 32'(fd0 + 1));
    end
    stall_pct = 0;

    // Field with no active lines produces no frame_done.
    fd0 = fd_cnt;
    for (int k = 0; k < 3; k++) cyc(1'b1, 3'b001, 8'h00);
    blank_v(1'b0, 4);
    chk("empty_field_no_frame_done", 32'(fd_cnt), 32'(fd0));

    // Reset in the middle of line 5.
    for (int r = 0; r < 5; r++) begin
      clear_px(); set_run(100 + 10 * r, 120 + 10 * r);
      send_line(640, 1'b0, 1'b0, -1, 0, -1, 1'b1, r);
    end
    rv0 = rv_cnt;
    fd0 = fd_cnt;
    clear_px(); set_run(310, 330);
    send_line(640, 1'b0, 1'b0, -1, 0, 320, 1'b0, 0);
    send_line(640, 1'b0, 1'b0, -1, 0, -1, 1'b0, 0);
    chk("post_reset_no_rows", 32'(rv_cnt), 32'(rv0));
    blank_v(1'b1, 5);
    chk("post_reset_no_frame_done", 32'(fd_cnt), 32'(fd0));
    clear_px(); set_run(500, 520);
    send_line(640, 1'b1, 1'b1, -1, 0, -1, 1'b1, 0);
    blank_v(1'b1, 3);
    chk("post_reset_frame_done", 32'(fd_cnt), 32'(fd0 + 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
